// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall, flush and operand forwarding.
// Define ID_EX_FORWARD_EN to compile in EXM/WB forwarding and stall capture of WB results.
module id_ex_stage #(
    parameter int SIZE     = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [SIZE-1:0]     id_pc,
    input  logic [SIZE-1:0]     id_rs1_data,
    input  logic [SIZE-1:0]     id_rs2_data,
    input  logic [SIZE-1:0]     id_imm,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic [3:0]          id_operation,
    input  logic                id_src_a,
    input  logic                id_src_b,
    input  logic                id_reg_write,
    input  logic [REG_ADDR-1:0] exm_rd,
    input  logic                exm_reg_write,
    input  logic [SIZE-1:0]     exm_result,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic                wb_reg_write,
    input  logic [SIZE-1:0]     wb_result,
    output logic [SIZE-1:0]     alu_a,
    output logic [SIZE-1:0]     alu_b,
    output logic [3:0]          alu_operation,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic [REG_ADDR-1:0] ex_rd,
    output logic [SIZE-1:0]     ex_pc,
    output logic [SIZE-1:0]     ex_store_data
);
    logic [SIZE-1:0]     rs1_data_q, rs2_data_q, imm_q;
    logic [REG_ADDR-1:0] rs1_q, rs2_q;
    logic                src_a_q, src_b_q;
    logic [SIZE-1:0]     rs1_fwd, rs2_fwd;
`ifdef ID_EX_FORWARD_EN
    logic exm_hit1, exm_hit2, wb_hit1, wb_hit2;
    // x0 is excluded so a stale write to register 0 never leaks into an operand
    always_comb begin
        exm_hit1 = exm_reg_write && exm_rd != '0 && exm_rd == rs1_q;
        exm_hit2 = exm_reg_write && exm_rd != '0 && exm_rd == rs2_q;
        wb_hit1  = wb_reg_write && wb_rd != '0 && wb_rd == rs1_q;
        wb_hit2  = wb_reg_write && wb_rd != '0 && wb_rd == rs2_q;
        rs1_fwd  = exm_hit1 ? exm_result : wb_hit1 ? wb_result : rs1_data_q;
        rs2_fwd  = exm_hit2 ? exm_result : wb_hit2 ? wb_result : rs2_data_q;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result, rs1_q, rs2_q};
    always_comb begin
        rs1_fwd = rs1_data_q;
        rs2_fwd = rs2_data_q;
    end
`endif
    always_comb begin
        alu_a         = src_a_q ? ex_pc : rs1_fwd;
        alu_b         = src_b_q ? imm_q : rs2_fwd;
        ex_store_data = rs2_fwd;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_rd         <= '0;
            ex_pc         <= '0;
            alu_operation <= 4'd0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            src_a_q       <= 1'b0;
            src_b_q       <= 1'b0;
        end else if (stall) begin
`ifdef ID_EX_FORWARD_EN
            // the WB write lands in the register file this cycle, so the held copy must absorb it
            if (wb_hit1) rs1_data_q <= wb_result;
            if (wb_hit2) rs2_data_q <= wb_result;
`endif
        end else begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write;
            ex_rd         <= id_rd;
            ex_pc         <= id_pc;
            alu_operation <= id_operation;
            rs1_data_q    <= id_rs1_data;
            rs2_data_q    <= id_rs2_data;
            imm_q         <= id_imm;
            rs1_q         <= id_rs1;
            rs2_q         <= id_rs2;
            src_a_q       <= id_src_a;
            src_b_q       <= id_src_b;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus randomized run against a transaction-level model.
// Expectations follow ID_EX_FORWARD_EN the same way the design does.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct packed {
        logic rst, stall, flush, valid;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] op;
        logic sa, sb, rw;
    } ins_t;
    typedef struct packed {
        logic [4:0] exm_rd; logic exm_w; logic [31:0] exm_res;
        logic [4:0] wb_rd;  logic wb_w;  logic [31:0] wb_res;
    } fw_t;
    typedef struct packed {
        logic valid, rw; logic [4:0] rd; logic [3:0] op;
        logic [31:0] pc, a, b, st;
    } ex_t;
    typedef struct { ins_t i; fw_t f; ex_t e; } vec_t;

    logic clk = 0, reset, stall, flush, id_valid, id_src_a, id_src_b, id_reg_write;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, exm_result, wb_result;
    logic [4:0] id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
    logic [3:0] id_operation, alu_operation;
    logic exm_reg_write, wb_reg_write, ex_valid, ex_reg_write;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [4:0] ex_rd;
    int passed = 0, total = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_operation(id_operation),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    function automatic ins_t ins(logic rst, logic stl, logic fl, logic v, logic [31:0] pc, logic [31:0] r1d,
                                 logic [31:0] r2d, logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [4:0] rd, logic [3:0] op, logic sa, logic sb, logic rw);
        ins_t x;
        x = '{rst, stl, fl, v, pc, r1d, r2d, imm, rs1, rs2, rd, op, sa, sb, rw};
        return x;
    endfunction
    function automatic fw_t fw(logic [4:0] er, logic ew, logic [31:0] ev, logic [4:0] wr, logic ww, logic [31:0] wv);
        fw_t x;
        x = '{er, ew, ev, wr, ww, wv};
        return x;
    endfunction
    function automatic ex_t ex(logic v, logic rw, logic [4:0] rd, logic [3:0] op, logic [31:0] pc,
                               logic [31:0] a, logic [31:0] b, logic [31:0] st);
        ex_t x;
        x = '{v, rw, rd, op, pc, a, b, st};
        return x;
    endfunction

    task automatic drive_ins(input ins_t x);
        reset = x.rst; stall = x.stall; flush = x.flush; id_valid = x.valid;
        id_pc = x.pc; id_rs1_data = x.r1d; id_rs2_data = x.r2d; id_imm = x.imm;
        id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd; id_operation = x.op;
        id_src_a = x.sa; id_src_b = x.sb; id_reg_write = x.rw;
    endtask
    task automatic drive_fw(input fw_t f);
        exm_rd = f.exm_rd; exm_reg_write = f.exm_w; exm_result = f.exm_res;
        wb_rd = f.wb_rd; wb_reg_write = f.wb_w; wb_result = f.wb_res;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask
    task automatic chk_all(input string tag, input ex_t e);
        chk({tag, " ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
        chk({tag, " ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
        chk({tag, " ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
        chk({tag, " alu_operation"}, {28'd0, alu_operation}, {28'd0, e.op});
        chk({tag, " ex_pc"}, ex_pc, e.pc);
        chk({tag, " alu_a"}, alu_a, e.a);
        chk({tag, " alu_b"}, alu_b, e.b);
        chk({tag, " ex_store_data"}, ex_store_data, e.st);
    endtask

    // transaction-level view of the instruction held in EX
    ins_t m;
    function automatic logic [31:0] operand(logic [4:0] idx, logic [31:0] held);
        if (FWD && idx != 0 && exm_reg_write && exm_rd == idx) return exm_result;
        if (FWD && idx != 0 && wb_reg_write && wb_rd == idx) return wb_result;
        return held;
    endfunction

    vec_t v[17];
    initial begin
        fw_t z;
        ex_t e0;
        z = fw(0, 0, 0, 0, 0, 0);
        e0 = ex(0, 0, 0, 0, 0, 0, 0, 0);
        v[0]  = '{ins(1,0,0,1,'h100,5,6,7,1,2,3,5,0,0,1), z, e0};
        v[1]  = '{ins(1,0,0,1,'h100,5,6,7,1,2,3,5,0,0,1), z, e0};
        v[2]  = '{ins(0,0,0,1,'h40,5,7,'h11,1,2,3,0,0,0,1), z, ex(1,1,3,0,'h40,5,7,7)};
        v[3]  = '{ins(0,0,0,1,'h80,5,7,'h33,1,2,4,2,1,1,0), z, ex(1,0,4,2,'h80,'h80,'h33,7)};
        v[4]  = '{ins(0,0,0,1,'hC0,'h5a,'h66,0,3,6,7,1,0,0,1), fw(3,1,'h10,3,1,'h20),
                  ex(1,1,7,1,'hC0,FWD ? 32'h10 : 32'h5a,'h66,'h66)};
        v[5]  = '{ins(0,1,0,0,'h999,1,2,3,9,9,9,9,1,1,0), fw(3,0,'h10,3,1,'h20),
                  ex(1,1,7,1,'hC0,FWD ? 32'h20 : 32'h5a,'h66,'h66)};
        v[6]  = '{ins(0,1,0,1,'h888,1,2,3,9,9,9,9,1,1,0), z,
                  ex(1,1,7,1,'hC0,FWD ? 32'h20 : 32'h5a,'h66,'h66)};
        v[7]  = '{ins(0,0,0,1,'h10,'h12,0,0,0,0,0,3,0,0,0), fw(0,1,'hFF,0,1,'hEE), ex(1,0,0,3,'h10,'h12,0,0)};
        v[8]  = '{ins(0,0,0,1,'h20,1,2,5,4,5,8,4,0,0,1), z, ex(1,1,8,4,'h20,1,2,2)};
        v[9]  = '{ins(0,1,0,0,'h777,3,3,3,1,1,1,1,1,1,0), fw(0,0,0,4,1,9), ex(1,1,8,4,'h20,FWD ? 32'd9 : 32'd1,2,2)};
        v[10] = '{ins(0,1,0,0,'h777,3,3,3,1,1,1,1,1,1,0), z, ex(1,1,8,4,'h20,FWD ? 32'd9 : 32'd1,2,2)};
        v[11] = '{ins(0,0,0,1,'h24,'h77,3,'h44,9,10,11,6,0,1,1), fw(10,1,'hAB,9,0,'hCD),
                  ex(1,1,11,6,'h24,'h77,'h44,FWD ? 32'hAB : 32'd3)};
        v[12] = '{ins(0,1,1,1,'h28,1,2,3,1,2,3,7,1,1,1), z, e0};
        v[13] = '{ins(0,1,0,1,'h2c,4,4,4,1,2,3,7,0,0,1), fw(0,1,'h55,0,1,'h66), e0};
        v[14] = '{ins(0,0,0,1,'h30,'h31,'h32,'h33,12,13,14,8,0,0,1), z, ex(1,1,14,8,'h30,'h31,'h32,'h32)};
        v[15] = '{ins(1,1,0,1,'h34,1,1,1,1,1,1,1,0,0,1), z, e0};
        v[16] = '{ins(0,0,0,1,'h38,5,7,0,15,16,17,9,0,0,1), fw(16,0,1,16,1,'hBEEF),
                  ex(1,1,17,9,'h38,5,FWD ? 32'hBEEF : 32'd7,FWD ? 32'hBEEF : 32'd7)};

        drive_ins(ins(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        drive_fw(z);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive_ins(v[k].i);
            drive_fw(v[k].f);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", k), v[k].e);
        end

        m = '0;
        for (int c = 0; c < 400; c++) begin
            ins_t x;
            fw_t f;
            @(negedge clk);
            x = ins(c == 0 || $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    1'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            f = fw(5'($urandom_range(0, 7)), 1'($urandom), $urandom, 5'($urandom_range(0, 7)), 1'($urandom), $urandom);
            drive_ins(x);
            drive_fw(f);
            if (x.rst || x.flush) m = '0;
            else if (x.stall) begin
                if (FWD && f.wb_w && f.wb_rd != 0 && f.wb_rd == m.rs1) m.r1d = f.wb_res;
                if (FWD && f.wb_w && f.wb_rd != 0 && f.wb_rd == m.rs2) m.r2d = f.wb_res;
            end else m = x;
            @(posedge clk);
            #1 drive_fw(fw(5'($urandom_range(0, 7)), 1'($urandom), $urandom, 5'($urandom_range(0, 7)), 1'($urandom), $urandom));
            #1 chk_all($sformatf("rnd%0d", c), ex(m.valid, m.rw, m.rd, m.op, m.pc,
                       m.sa ? m.pc : operand(m.rs1, m.r1d), m.sb ? m.imm : operand(m.rs2, m.r2d),
                       operand(m.rs2, m.r2d)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter SIZE, default 32: datapath width of all operand, PC, immediate and result ports.
REQ-002 SHALL have parameter REG_ADDR, default 5: register-index width.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 STALL  in  1  hold the stage contents.
REQ-006 FLUSH  in  1  replace the next stage contents with a bubble.
REQ-007 ID_VALID  in  1  the decode stage presents a valid instruction.
REQ-008 ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM  in  SIZE each  decode-stage PC, register-file reads and immediate.
REQ-009 ID_RS1, ID_RS2, ID_RD  in  REG_ADDR each  source and destination indices.
REQ-010 ID_OPERATION  in  4  ALU operation code.
REQ-011 ID_SRC_A, ID_SRC_B, ID_REG_WRITE  in  1 each:
  - ID_SRC_A: 0 = rs1, 1 = PC.
  - ID_SRC_B: 0 = rs2, 1 = IMM.
  - ID_REG_WRITE: the instruction writes rd.
REQ-012 Forwarding sources, inputs:
  - EXM_RD (REG_ADDR), EXM_REG_WRITE (1), EXM_RESULT (SIZE): the instruction one stage ahead.
  - WB_RD (REG_ADDR), WB_REG_WRITE (1), WB_RESULT (SIZE): the instruction two stages ahead, also the register-file write port.
REQ-013 ALU_A, ALU_B  out  SIZE  ALU operands.
REQ-014 ALU_OPERATION  out  4  registered operation code.
REQ-015 EX_VALID, EX_REG_WRITE  out  1 each; EX_RD  out  REG_ADDR; EX_PC  out  SIZE.
REQ-016 EX_STORE_DATA  out  SIZE  forwarded rs2 value, independent of ID_SRC_B.

Function
REQ-017 Each rising edge with RESET=0, FLUSH=0, STALL=0: SHALL register every ID_* input; EX_VALID <= ID_VALID.
REQ-018 FLUSH=1 SHALL load a bubble:
  - EX_VALID=0, EX_REG_WRITE=0, ALU_OPERATION=4'd0, EX_RD=0.
  - All data registers cleared to 0.
  - FLUSH has priority over STALL.
REQ-019 STALL=1 and FLUSH=0 SHALL hold all registers, except as stated in REQ-020.
REQ-020 Stall capture: while stalled, if WB_REG_WRITE=1, WB_RD!=0 and WB_RD equals the held rs1 or rs2 index, the matching held data register SHALL load WB_RESULT.
REQ-021 Forwarding SHALL be combinational from the registered state to the outputs, evaluated per source operand:
  - First priority: EXM_RESULT, when EXM_REG_WRITE=1, EXM_RD!=0 and EXM_RD==rs.
  - Otherwise WB_RESULT under the same conditions.
  - Otherwise the registered data.
REQ-022 Register index 0 SHALL never be forwarded; the registered data is always used for x0.
REQ-023 ALU_A SHALL equal the registered PC if SRC_A=1, else forwarded rs1.
REQ-024 ALU_B SHALL equal the registered IMM if SRC_B=1, else forwarded rs2.
REQ-025 EX_STORE_DATA SHALL always equal forwarded rs2.
REQ-026 Latency: ID inputs SHALL appear at the outputs exactly 1 cycle after capture; forwarding adds 0 cycles.
REQ-027 Outputs of an invalid stage (EX_VALID=0) SHALL still follow REQ-021 to REQ-025; consumers qualify with EX_VALID.

Reset
REQ-028 RESET=1 at a clock edge SHALL clear every register to 0, giving:
  - EX_VALID=0, EX_REG_WRITE=0, EX_RD=0, EX_PC=0, ALU_OPERATION=4'd0.
  - ALU_A, ALU_B and EX_STORE_DATA equal to 0 unless forwarding is active.
REQ-029 RESET SHALL override FLUSH and STALL.
REQ-030 RESET asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-031 Macro ID_EX_FORWARD_EN defined: forwarding (REQ-021, REQ-022) and stall capture (REQ-020) SHALL be compiled in.
REQ-032 Macro ID_EX_FORWARD_EN undefined:
  - Operands come only from registered data.
  - EXM_* and WB_* inputs are ignored.
  - STALL performs a pure hold.
  - The port list is unchanged.

Verification
REQ-033 Reset: RESET=1 for 2 cycles with ID_VALID=1 -> EX_VALID=0, ALU_OPERATION=0, EX_PC=0.
REQ-034 Pass-through: capture rs1data=5, rs2data=7, OP=4'd0, SRC=0/0 -> next cycle ALU_A=5, ALU_B=7, EX_VALID=1.
REQ-035 Forward priority (with ID_EX_FORWARD_EN): rs1=3; EXM_RD=3, EXM_RESULT=0x10; WB_RD=3, WB_RESULT=0x20 -> ALU_A=0x10. Drop EXM_REG_WRITE -> ALU_A=0x20.
REQ-036 x0 guard: rs2=0, EXM_RD=0, EXM_REG_WRITE=1, EXM_RESULT=0xFF, registered rs2data=0 -> ALU_B=0 and EX_STORE_DATA=0.
REQ-037 Stall capture: stall with rs1=4, held data=1; WB_RD=4, WB_RESULT=9 for 1 cycle; release stall with WB idle -> ALU_A=9.
REQ-038 FLUSH with STALL: FLUSH=1 and STALL=1 together -> next cycle EX_VALID=0, EX_REG_WRITE=0. Without the macro, REQ-035 stimulus -> ALU_A equals the registered rs1data.
